// File: rtl/winker_pkg.sv
// Shared types and defaults for the turn-signal sequencer.
package winker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT,
        ST_HAZARD,
        ST_FINISH
    } state_e;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_HAZARD = 2'd3;

    localparam int DEF_HALF_PERIOD    = 50;
    localparam int DEF_COMFORT_BLINKS = 3;

endpackage

// File: rtl/winker_blink_timer.sv
// Half-period counter and lamp phase; restart forces a fresh on-half.
module winker_blink_timer #(
    parameter int HALF_PERIOD = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic enable_i,
    output logic phase_o,
    output logic on_last_o
);

    localparam int CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (enable_i) begin
            if (wrap) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end
    end

    assign phase_o   = phase_q;
    assign on_last_o = enable_i & phase_q & wrap;

endmodule

// File: rtl/winker_controller.sv
// Turn-signal arbiter/sequencer with comfort auto-cancel and blink counting.
// Hazard mode is built only when WINKER_HAZARD_EN is defined.
module winker_controller import winker_pkg::*; #(
    parameter int HALF_PERIOD    = DEF_HALF_PERIOD,
    parameter int COMFORT_BLINKS = DEF_COMFORT_BLINKS,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             comfort,
    input  logic             hazard,
    input  logic             off,
    output logic             lamp_left,
    output logic             lamp_right,
    output logic [1:0]       mode,
    output logic             busy,
    output logic [CNT_W-1:0] blink_count,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] COMFORT_N = CNT_W'(COMFORT_BLINKS);

    state_e            state_q, state_d;
    logic              comfort_q, comfort_d;
    logic [CNT_W-1:0]  blink_q, blink_d, blink_inc;
    logic              entry, one_req, hz_on, phase, on_last;

`ifdef WINKER_HAZARD_EN
    assign hz_on = hazard;
`else
    logic unused_hazard;
    assign unused_hazard = hazard;
    assign hz_on         = 1'b0;
`endif

    assign one_req   = left_req ^ right_req;
    assign blink_inc = (blink_q == CNT_MAX) ? blink_q : blink_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        comfort_d = comfort_q;
        entry     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hz_on) begin
                    state_d   = ST_HAZARD;
                    comfort_d = 1'b0;
                    entry     = 1'b1;
                end else if (one_req) begin
                    state_d   = left_req ? ST_LEFT : ST_RIGHT;
                    comfort_d = comfort;
                    entry     = 1'b1;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (hz_on) begin
                    state_d   = ST_HAZARD;
                    comfort_d = 1'b0;
                    entry     = 1'b1;
                end else if (off) begin
                    state_d = ST_FINISH;
                end else if (one_req) begin
                    // Same side re-enters too, restarting phase, count and comfort.
                    state_d   = left_req ? ST_LEFT : ST_RIGHT;
                    comfort_d = comfort;
                    entry     = 1'b1;
                end else if (comfort_q && on_last && blink_inc == COMFORT_N) begin
                    state_d = ST_FINISH;
                end
            end
`ifdef WINKER_HAZARD_EN
            ST_HAZARD: if (!hazard) state_d = ST_FINISH;
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (entry || state_d == ST_IDLE) blink_d = '0;
        else if (on_last)                blink_d = blink_inc;
        else                             blink_d = blink_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            comfort_q <= 1'b0;
            blink_q   <= '0;
        end else begin
            state_q   <= state_d;
            comfort_q <= comfort_d;
            blink_q   <= blink_d;
        end
    end

    winker_blink_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .restart_i (entry),
        .enable_i  (busy),
        .phase_o   (phase),
        .on_last_o (on_last)
    );

    // Outputs decode only registered state, so no input reaches them combinationally.
    always_comb begin
        lamp_left  = 1'b0;
        lamp_right = 1'b0;
        mode       = MODE_IDLE;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_LEFT: begin
                lamp_left = phase;
                mode      = MODE_LEFT;
                busy      = 1'b1;
            end
            ST_RIGHT: begin
                lamp_right = phase;
                mode       = MODE_RIGHT;
                busy       = 1'b1;
            end
`ifdef WINKER_HAZARD_EN
            ST_HAZARD: begin
                lamp_left  = phase;
                lamp_right = phase;
                mode       = MODE_HAZARD;
                busy       = 1'b1;
            end
`endif
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    assign blink_count = blink_q;

endmodule

// File: doc/winker_controller.md
# winker_controller

Turn-signal sequencer that sits above the winker lamp outputs. It accepts stalk requests (left, right, comfort-tap), a hazard switch and an off command, and arbitrates between them. It generates the blink timing with an internal half-period counter and counts completed blinks. It auto-cancels comfort (lane-change) blinks after a fixed count and reports a one-cycle completion pulse to the body-control logic.

## Interface
Parameters:
- HALF_PERIOD, 50: clock cycles per lamp-on half and per lamp-off half; must be ≥2
- COMFORT_BLINKS, 3: completed blinks before a comfort request auto-finishes; range 1..255
- CNT_W, 8: width of the blink counter and blink_count output

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- left_req  in  1  one-cycle pulse, request left indication
- right_req  in  1  one-cycle pulse, request right indication
- comfort  in  1  sampled with left_req/right_req; 1 = auto-cancel after COMFORT_BLINKS
- hazard  in  1  level, hazard switch
- off  in  1  one-cycle pulse, cancel active direction indication
- lamp_left  out  1  left lamp drive
- lamp_right  out  1  right lamp drive
- mode  out  2  current state code: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD
- busy  out  1  1 in LEFT, RIGHT, HAZARD
- blink_count  out  CNT_W  completed blinks in the current mode, saturating at all-ones
- done  out  1  one-cycle pulse in FINISH

## Operation
- States: IDLE, LEFT, RIGHT, HAZARD, FINISH. FINISH reports mode 0 with busy=0.
- Priority per cycle: reset > hazard > off > direction request > comfort expiry.
- IDLE:
  - hazard=1 → HAZARD.
  - Otherwise, exactly one of left_req/right_req → LEFT/RIGHT, latching comfort.
  - Both requests set together are ignored. off is ignored.
- LEFT/RIGHT:
  - hazard=1 → HAZARD.
  - off → FINISH.
  - Opposite-side request → the other side, re-entered fresh with comfort re-latched.
  - Same-side request restarts the mode: phase, counter and comfort flag all reset.
  - Both requests set together are ignored.
- HAZARD: direction requests and off are ignored. hazard=0 → FINISH.
- FINISH: lasts one cycle with done=1, then IDLE. Requests arriving in FINISH are dropped.
- Phase generator:
  - Every mode entry sets phase=1 (on) and clears the half-period counter.
  - The counter runs 0..HALF_PERIOD-1; at HALF_PERIOD-1 phase toggles and the counter wraps to 0.
- Lamps:
  - LEFT: lamp_left=phase.
  - RIGHT: lamp_right=phase.
  - HAZARD: both lamps = phase.
  - All other states: both lamps 0.
- blink_count:
  - Cleared on every mode entry.
  - Increments on the last cycle of each on-half, saturating at 2^CNT_W-1.
- Comfort expiry: with the comfort flag set, the cycle where blink_count becomes COMFORT_BLINKS is the last lamp-on cycle; the next cycle is FINISH.

## Timing
- Reset values: lamps 0, mode 0, busy 0, blink_count 0, done 0; state IDLE, phase 0, counters 0.
- Request at cycle n → new state and lamp=1 at cycle n+1 (one-cycle latency). The first on-half lasts exactly HALF_PERIOD cycles.
- off or hazard fall at cycle n → FINISH at n+1 (lamps 0, done 1) → IDLE at n+2.
- Reset asserted mid-blink forces reset values on the next edge, regardless of other inputs.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- WINKER_HAZARD_EN defined: HAZARD state and the hazard input are active as described.
- Undefined: the hazard input is ignored; HAZARD is unreachable and its encoding is not decoded. mode never reports 3. The hazard port remains present so port lists match.

## Structure
- Package winker_pkg holds:
  - the state enum (IDLE, LEFT, RIGHT, HAZARD, FINISH) and mode code constants;
  - the default HALF_PERIOD and COMFORT_BLINKS values.
- Sub-module winker_blink_timer holds the half-period counter and phase toggle.
  - Inputs: restart, enable. Outputs: phase, on_last (last cycle of an on-half).
  - It is instantiated once. The FSM and blink counter stay in the top.

## Test plan
Benches use HALF_PERIOD=4, COMFORT_BLINKS=3.
- Left request, no comfort: left_req at cycle 10 → lamp_left=1 at cycles 11–14, 0 at 15–18, 1 at 19–22; blink_count=1 at 15, 2 at 23; lamp_right stays 0.
- Comfort left: left_req + comfort at cycle 10 → on-halves at 11–14, 19–22, 27–30; FINISH/done=1 at 31; IDLE at 32; blink_count=3 at cycle 31 before clearing.
- Direction change and restart:
  - right_req at cycle 17 during LEFT → mode=2 and lamp_right=1 at 18, blink_count=0.
  - right_req again at 20 → counter restarts; lamp_right on at 21–24.
- Hazard preemption: hazard=1 at cycle 13 during LEFT → both lamps 1 at 14–17; off at 15 is ignored; hazard=0 at 30 → done at 31, IDLE at 32. With WINKER_HAZARD_EN undefined, LEFT continues unaffected.
- Edge cases:
  - left_req and right_req together in IDLE → stays IDLE.
  - off in IDLE → no done.
  - reset=1 at cycle 20 during RIGHT → all outputs at reset values at cycle 21.
